// File: rtl/interface_lane_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : interface_lane_arbiter_if
// Purpose  : Bundles the five request lanes, the lane select and the shared
//            downstream channel of interface_lane_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface interface_lane_arbiter_if #(
  parameter int ERR_W = 8
);
  logic [15:0]      io_in_0_data;
  logic             io_in_0_valid;
  logic [4:0]       io_in_0_parity;
  logic             io_in_0_ready;
  logic [15:0]      io_in_1_data;
  logic             io_in_1_valid;
  logic [4:0]       io_in_1_parity;
  logic             io_in_1_ready;
  logic [15:0]      io_in_2_data;
  logic             io_in_2_valid;
  logic [4:0]       io_in_2_parity;
  logic             io_in_2_ready;
  logic [15:0]      io_in_3_data;
  logic             io_in_3_valid;
  logic [4:0]       io_in_3_parity;
  logic             io_in_3_ready;
  logic [15:0]      io_in_4_data;
  logic             io_in_4_valid;
  logic [4:0]       io_in_4_parity;
  logic             io_in_4_ready;
  logic [2:0]       io_sel;
  logic [15:0]      io_out_data;
  logic             io_out_valid;
  logic [4:0]       io_out_parity;
  logic [2:0]       io_out_grant;
  logic             io_out_ready;
  logic [ERR_W-1:0] io_err_count;

  // Arbiter side
  modport slave (
    input  io_in_0_data, io_in_0_valid, io_in_0_parity,
    input  io_in_1_data, io_in_1_valid, io_in_1_parity,
    input  io_in_2_data, io_in_2_valid, io_in_2_parity,
    input  io_in_3_data, io_in_3_valid, io_in_3_parity,
    input  io_in_4_data, io_in_4_valid, io_in_4_parity,
    output io_in_0_ready, io_in_1_ready, io_in_2_ready, io_in_3_ready, io_in_4_ready,
    input  io_sel, io_out_ready,
    output io_out_data, io_out_valid, io_out_parity, io_out_grant, io_err_count
  );

  // Lane producers plus consumer side
  modport master (
    output io_in_0_data, io_in_0_valid, io_in_0_parity,
    output io_in_1_data, io_in_1_valid, io_in_1_parity,
    output io_in_2_data, io_in_2_valid, io_in_2_parity,
    output io_in_3_data, io_in_3_valid, io_in_3_parity,
    output io_in_4_data, io_in_4_valid, io_in_4_parity,
    input  io_in_0_ready, io_in_1_ready, io_in_2_ready, io_in_3_ready, io_in_4_ready,
    output io_sel, io_out_ready,
    input  io_out_data, io_out_valid, io_out_parity, io_out_grant, io_err_count
  );
endinterface
`default_nettype wire

// File: rtl/interface_lane_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : interface_lane_arbiter
// Purpose  : Five-lane round-robin arbiter with burst lock and optional fixed
//            lane select, feeding one registered 16-bit output stage with
//            ready/valid backpressure.
// Options  : PARITY_CHECK_EN - drop and count beats with bad parity.
// Revision : 1.0 - initial release
// ============================================================================
module interface_lane_arbiter #(
  parameter int NUM_LANES = 5,
  parameter int MAX_BURST = 4,
  parameter int ERR_W     = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  interface_lane_arbiter_if.slave       bus
);

  localparam logic [3:0] MAX_BURST_C = 4'(MAX_BURST);

  // Per-lane views of the flattened interface
  logic [15:0]          lane_data   [NUM_LANES];
  logic [4:0]           lane_parity [NUM_LANES];
  logic [NUM_LANES-1:0] lane_valid;
  logic [NUM_LANES-1:0] lane_ready;

  assign lane_data[0] = bus.io_in_0_data;  assign lane_parity[0] = bus.io_in_0_parity;
  assign lane_data[1] = bus.io_in_1_data;  assign lane_parity[1] = bus.io_in_1_parity;
  assign lane_data[2] = bus.io_in_2_data;  assign lane_parity[2] = bus.io_in_2_parity;
  assign lane_data[3] = bus.io_in_3_data;  assign lane_parity[3] = bus.io_in_3_parity;
  assign lane_data[4] = bus.io_in_4_data;  assign lane_parity[4] = bus.io_in_4_parity;
  assign lane_valid = {bus.io_in_4_valid, bus.io_in_3_valid, bus.io_in_2_valid,
                       bus.io_in_1_valid, bus.io_in_0_valid};
  assign bus.io_in_0_ready = lane_ready[0];
  assign bus.io_in_1_ready = lane_ready[1];
  assign bus.io_in_2_ready = lane_ready[2];
  assign bus.io_in_3_ready = lane_ready[3];
  assign bus.io_in_4_ready = lane_ready[4];

  // State
  logic        out_valid_q, out_valid_d;
  logic [15:0] out_data_q,  out_data_d;
  logic [4:0]  out_parity_q, out_parity_d;
  logic [2:0]  out_grant_q, out_grant_d;
  logic [2:0]  ptr_q, ptr_d;       // last lane that won a fresh burst
  logic [3:0]  burst_q, burst_d;   // beats granted to ptr_q in this burst
  logic [2:0]  sel_q;              // previous io_sel, for change detection

  // Arbitration wires
  logic                 load;
  logic                 rr_mode;
  logic [NUM_LANES-1:0] elig;
  logic                 any_elig;
  logic                 lock_active;
  logic [2:0]           win;
  logic                 found;
  logic [3:0]           scan_idx;
  logic                 accept;
  logic                 beat_ok;
  logic                 sel_changed;

  assign load        = !out_valid_q | bus.io_out_ready;
  assign rr_mode     = bus.io_sel > 3'd4;
  assign sel_changed = bus.io_sel != sel_q;
  assign any_elig    = |elig;
  assign accept      = reset & load & any_elig;
  // A lock only holds while the burst is short and the locked lane still asks
  assign lock_active = (burst_q != 4'd0) && (burst_q < MAX_BURST_C) && elig[ptr_q];

  // Eligibility mask from the current lane select
  always_comb begin
    elig = '0;
    for (int n = 0; n < NUM_LANES; n++) begin
      elig[n] = lane_valid[n] & (rr_mode | (bus.io_sel == 3'(n)));
    end
  end

  // Winner: locked lane, else first eligible lane after the pointer
  always_comb begin
    win      = ptr_q;
    found    = 1'b0;
    scan_idx = 4'd0;
    for (int i = 1; i <= NUM_LANES; i++) begin
      scan_idx = {1'b0, ptr_q} + 4'(i);
      if (scan_idx >= 4'(NUM_LANES)) scan_idx = scan_idx - 4'(NUM_LANES);
      if (!found && elig[scan_idx[2:0]]) begin
        found = 1'b1;
        win   = scan_idx[2:0];
      end
    end
    if (lock_active) win = ptr_q;
  end

  // Exactly the winning lane sees ready, and only when the stage can load
  always_comb begin
    lane_ready = '0;
    for (int n = 0; n < NUM_LANES; n++) begin
      lane_ready[n] = accept & (win == 3'(n));
    end
  end

`ifdef PARITY_CHECK_EN
  logic [ERR_W-1:0] err_q, err_d;
  logic [4:0]       calc_parity;

  // Expected parity of the winning beat: one bit per nibble plus whole word
  always_comb begin
    calc_parity[0] = ^lane_data[win][3:0];
    calc_parity[1] = ^lane_data[win][7:4];
    calc_parity[2] = ^lane_data[win][11:8];
    calc_parity[3] = ^lane_data[win][15:12];
    calc_parity[4] = ^lane_data[win];
  end

  assign beat_ok = calc_parity == lane_parity[win];

  // Saturating count of consumed-but-dropped beats
  always_comb begin
    err_d = err_q;
    if (accept && !beat_ok && (err_q != {ERR_W{1'b1}})) err_d = err_q + 1'b1;
  end

  // Error counter register
  always_ff @(posedge clock) begin
    if (!reset) err_q <= '0;
    else        err_q <= err_d;
  end

  assign bus.io_err_count = err_q;
`else
  assign beat_ok          = 1'b1;
  assign bus.io_err_count = {ERR_W{1'b0}};
`endif

  // Next state for the output stage and the burst/pointer tracking
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_parity_d = out_parity_q;
    out_grant_d  = out_grant_q;
    ptr_d        = ptr_q;
    burst_d      = burst_q;

    if (load) begin
      out_valid_d = accept & beat_ok;
      if (accept && beat_ok) begin
        out_data_d   = lane_data[win];
        out_parity_d = lane_parity[win];
        out_grant_d  = win;
      end
    end

    // Locked lane withdrew: its burst is over
    if ((burst_q != 4'd0) && !lane_valid[ptr_q]) burst_d = 4'd0;

    if (accept) begin
      if ((burst_q != 4'd0) && (win == ptr_q)) begin
        if (burst_q < MAX_BURST_C) burst_d = burst_q + 4'd1;
      end else begin
        burst_d = 4'd1;
        ptr_d   = win;
      end
    end

    // A mode change restarts burst accounting
    if (sel_changed) burst_d = 4'd0;
  end

  // State registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_parity_q <= '0;
      out_grant_q  <= '0;
      ptr_q        <= 3'd4;
      burst_q      <= 4'd0;
      sel_q        <= bus.io_sel;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_parity_q <= out_parity_d;
      out_grant_q  <= out_grant_d;
      ptr_q        <= ptr_d;
      burst_q      <= burst_d;
      sel_q        <= bus.io_sel;
    end
  end

  assign bus.io_out_valid  = out_valid_q;
  assign bus.io_out_data   = out_data_q;
  assign bus.io_out_parity = out_parity_q;
  assign bus.io_out_grant  = out_grant_q;

endmodule
`default_nettype wire

// File: doc/interface_lane_arbiter.md
Name: interface_lane_arbiter

Overview:
- Shares one downstream 16-bit data/valid/parity channel among the five lane interfaces the interface_connect block passes through.
- Arbitrates with round-robin plus a burst lock, or locks to a single lane chosen by io_sel.
- Adds ready/valid backpressure and one registered output stage.
- Sits between the interface_connect outputs and the single shared consumer.

Parameters:
- NUM_LANES, 5, number of requesting lanes; fixed at 5 because the ports are flattened per lane.
- MAX_BURST, 4, maximum consecutive beats granted to one lane while other lanes are requesting; legal range 1..15.
- ERR_W, 8, width of the parity error counter.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on rising clock)
- io_in_N_data  in  16  lane N payload, N=0..4
- io_in_N_valid  in  1  lane N beat valid
- io_in_N_parity  in  5  lane N parity: bit k (k=0..3) = XOR of data[4k+3:4k]; bit 4 = XOR of data[15:0]
- io_in_N_ready  out  1  lane N beat accepted this cycle
- io_sel  in  3  values 0..4 lock arbitration to that lane; values 5..7 select round-robin
- io_out_data  out  16  registered payload
- io_out_valid  out  1  output holds a beat
- io_out_parity  out  5  registered parity, passed through unchanged
- io_out_grant  out  3  index of the lane that sourced the current output beat
- io_out_ready  in  1  consumer accepts the beat
- io_err_count  out  ERR_W  saturating count of dropped parity-error beats (see Optional Feature)

Behaviour:
- Reset (reset==0 at a clock edge) clears state:
  - io_out_valid=0, io_out_data=0, io_out_parity=0, io_out_grant=0.
  - Round-robin pointer=4, so lane 0 has first priority.
  - Burst counter=0; io_err_count=0.
  - All io_in_N_ready are held at 0 during reset.
- Load enable: load = !io_out_valid | io_out_ready.
- Eligible lanes:
  - io_sel in 0..4: only lane io_sel is eligible.
  - io_sel in 5..7: all lanes with valid=1 are eligible.
- Winner selection (combinational):
  - If the burst lock is active and the locked lane is still valid, the locked lane wins.
  - Otherwise, scan eligible valid lanes starting at pointer+1 modulo 5; the first found wins.
- io_in_N_ready = load & (N==winner) & any eligible valid. At most one ready is high per cycle. Ready never depends on io_in_N_ready of another lane.
- On accept (valid & ready of winner):
  - Output register loads data and parity; io_out_grant=winner; io_out_valid=1 next cycle.
  - Latency from input accept to output valid is 1 cycle.
- If load=1 and no lane is accepted, io_out_valid goes to 0 next cycle.
- If io_out_valid=1 and io_out_ready=0, the output holds stable and all readies are 0.
- Burst lock:
  - On an accept from the same lane as the previous accept, the counter increments; otherwise it is set to 1 and pointer=winner.
  - Lock is active while counter < MAX_BURST.
  - When counter reaches MAX_BURST and another eligible lane is valid, the lock releases and the scan starts after the locked lane.
  - If no other lane is requesting, the same lane keeps winning and the counter saturates at MAX_BURST.
- A lane dropping valid ends its lock immediately.
- Any io_sel change clears the burst counter on the next edge. The new mode applies combinationally in the same cycle.
- Simultaneous output drain and new accept in one cycle: the register reloads back-to-back, sustaining 1 beat/cycle.

Optional Feature:
- Macro: PARITY_CHECK_EN.
- Defined:
  - Every accepted beat is checked against the parity rule above.
  - On mismatch the beat is consumed (ready=1) but not loaded; io_out_valid follows the no-accept rule.
  - io_err_count increments by 1 and saturates at 2^ERR_W-1.
  - A dropped beat still advances the burst and pointer state as a normal accept.
- Undefined: no check is performed; all beats are forwarded; io_err_count is tied to 0.

Test Plan:
1. Reset, then lanes 0..4 all valid continuously, io_sel=5, io_out_ready=1, MAX_BURST=4 -> io_out_grant sequence 0,0,0,0,1,1,1,1,2,... with io_out_valid=1 every cycle from cycle 2.
2. io_sel=3 with all lanes valid -> only io_in_3_ready ever toggles; io_out_grant=3 for every beat; other readies stay 0.
3. Output valid with io_out_ready=0 for 5 cycles -> io_out_data stable, all io_in_N_ready=0; release -> next beat appears 1 cycle later.
4. Only lane 2 valid for 10 beats -> 10 consecutive grants to lane 2 without a gap; counter saturates; lane 4 raises valid -> lane 4 granted on the next accept.
5. PARITY_CHECK_EN defined: lane 1 sends data 0x0001 with parity 0x00 -> beat consumed, not output, io_err_count=1; correct parity 0x11 -> forwarded.
6. Assert reset=0 mid-burst with io_out_valid=1 -> next cycle io_out_valid=0, io_err_count=0, and after release lane 0 wins first.
